mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 op  in  7  opcode of the instruction register (IR[6:0]).
REQ-005 mem_ready  in  1  memory handshake: access completes in any cycle where mem_ready=1.
REQ-006 pc_update  out  1  PC write enable.
REQ-007 branch  out  1  branch qualify; datapath ANDs it with Zero.
REQ-008 ir_write  out  1  IR and OldPC write enable.
REQ-009 reg_write  out  1  register file write enable.
REQ-010 mem_write  out  1  data memory write request.
REQ-011 adr_src  out  1  memory address: 0=PC, 1=ALUOut.
REQ-012 result_src  out  2  00=ALUOut, 01=ReadData, 10=ALUResult.
REQ-013 alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 data.
REQ-014 alu_src_b  out  2  00=rs2 data, 01=ImmExt, 10=constant 4.
REQ-015 alu_op  out  2  00=add, 01=subtract/compare, 10=funct-decoded.
REQ-016 imm_src  out  2  01 for op=0100011, 10 for op=1100011, else 00; combinational from op.
REQ-017 state  out  4  current state encoding, for debug.
REQ-018 retire  out  1  one-cycle pulse on an instruction's final cycle.
REQ-019 illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-020 retired_cnt  out  16  count of retired instructions.

Function
REQ-021 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9; codes 10-15 are unreachable and SHALL go to FETCH on the next edge.
REQ-022 Outputs are Moore decodes of state, except the mem_ready gating in REQ-024 and REQ-027; any signal not listed for a state is 0.
REQ-023 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
REQ-024 FETCH: ir_write=pc_update=mem_ready; stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-025 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by op:
- 0000011 and 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- any other op -> FETCH, with illegal=1 for that cycle.
REQ-026 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; go to MEMREAD if op=0000011, else MEMWRITE.
REQ-027 MEMREAD: adr_src=1, result_src=00; wait while mem_ready=0, then go to MEMWB. MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until the mem_ready=1 cycle, then go to FETCH.
REQ-028 MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-029 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB. EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
REQ-030 ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-031 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 -> FETCH.
REQ-032 retire=1 in MEMWB, ALUWB and BEQ, and in MEMWRITE only when mem_ready=1.
REQ-033 retired_cnt increments by 1 in every cycle where retire=1 and wraps 0xFFFF->0x0000; illegal opcodes are not counted.
REQ-034 Latency with mem_ready held at 1, counted in cycles from FETCH: lw=5, sw=4, R-type=4, I-type=4, beq=3, illegal=2.
REQ-035 op is sampled only in DECODE and MEMADR; op changes in other states have no effect.

Reset
REQ-036 When rst=1 at a clock edge, the next state is FETCH and retired_cnt=0, regardless of current state or a pending mem_ready handshake; rst has priority over all transitions.
REQ-037 During the first cycle after reset, outputs are the FETCH values and retire=illegal=0.

Verification
REQ-038 Reset mid-MEMREAD with mem_ready=0 -> state=0 next cycle, retired_cnt=0, reg_write=0.
REQ-039 lw (op=0000011), mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and result_src=01 only in state 4; retired_cnt increments by 1.
REQ-040 sw with mem_ready=0 for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, retire once, then state=0.
REQ-041 beq (op=1100011) -> states 0,1,9; in state 9 branch=1, alu_op=01, imm_src=10.
REQ-042 op=1111111 in DECODE -> illegal=1 for one cycle, next state=0, retired_cnt unchanged.
REQ-043 Preload retired_cnt to 0xFFFF by running 65535 R-type instructions, then retire one more -> retired_cnt=0x0000.

Source files
------------

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master: the FSM (samples op/mem_ready, drives control); slave: the datapath side.
interface mc_control_if;
  logic [6:0]  op;
  logic        mem_ready;
  logic        pc_update;
  logic        branch;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        adr_src;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  imm_src;
  logic [3:0]  state;
  logic        retire;
  logic        illegal;
  logic [15:0] retired_cnt;

  modport master (
    input  op, mem_ready,
    output pc_update, branch, ir_write, reg_write, mem_write, adr_src, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, state, retire, illegal, retired_cnt
  );

  modport slave (
    output op, mem_ready,
    input  pc_update, branch, ir_write, reg_write, mem_write, adr_src, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, state, retire, illegal, retired_cnt
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V style control FSM. Control outputs are registered Moore
// decodes of the state; only the memory handshake (mem_ready) and the opcode
// check in DECODE are gated combinationally on top of the registered flags.
module mc_control_fsm (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus_io
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  // Registered per-state control flags.
  typedef struct packed {
    logic       fetch;       // pc_update/ir_write qualified by mem_ready
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;      // unconditional retire
    logic       retire_rdy;  // retire qualified by mem_ready
    logic       decode;      // illegal-opcode check enabled
  } ctrl_t;

  function automatic ctrl_t decode_state(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      StDecode: begin
        c.decode    = 1'b1;
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      StMemRead: c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      StMemWrite: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.retire_rdy = 1'b1;
      end
      StExecR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      StExecI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      StAluWb: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      StBeq: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
        c.retire    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] retired_cnt_q;
  logic        op_legal;
  logic        retire;

  // Opcode classification used by DECODE.
  always_comb begin
    op_legal = 1'b0;
    case (bus_io.op)
      OpLoad, OpStore, OpRType, OpIType, OpBranch: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = bus_io.mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (bus_io.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (bus_io.op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = bus_io.mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = bus_io.mem_ready ? StFetch : StMemWrite;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      default:    state_d = StFetch;  // unused encodings recover to FETCH
    endcase
  end

  // Control flags for the state being entered, registered alongside it.
  always_comb ctrl_d = decode_state(state_d);

  // State, registered controls and retire counter; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      ctrl_q        <= decode_state(StFetch);
      retired_cnt_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (retire) retired_cnt_q <= retired_cnt_q + 16'd1;
    end
  end

  // Output drive, including the mem_ready and opcode qualified pulses.
  always_comb begin
    retire             = ctrl_q.retire | (ctrl_q.retire_rdy & bus_io.mem_ready);
    bus_io.retire      = retire;
    bus_io.illegal     = ctrl_q.decode & ~op_legal;
    bus_io.pc_update   = ctrl_q.fetch & bus_io.mem_ready;
    bus_io.ir_write    = ctrl_q.fetch & bus_io.mem_ready;
    bus_io.branch      = ctrl_q.branch;
    bus_io.reg_write   = ctrl_q.reg_write;
    bus_io.mem_write   = ctrl_q.mem_write;
    bus_io.adr_src     = ctrl_q.adr_src;
    bus_io.result_src  = ctrl_q.result_src;
    bus_io.alu_src_a   = ctrl_q.alu_src_a;
    bus_io.alu_src_b   = ctrl_q.alu_src_b;
    bus_io.alu_op      = ctrl_q.alu_op;
    bus_io.state       = state_q;
    bus_io.retired_cnt = retired_cnt_q;
    if (bus_io.op == OpStore)       bus_io.imm_src = 2'b01;
    else if (bus_io.op == OpBranch) bus_io.imm_src = 2'b10;
    else                            bus_io.imm_src = 2'b00;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each scenario queues per-cycle stimulus and the
// expected state/controls/counter, then drives the cycles and compares.
module tb_mc_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control_fsm dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct packed {
    logic       r;
    logic [6:0] op;
    logic       mr;
  } stim_t;

  // ctl = {pc_update, branch, ir_write, reg_write, mem_write, adr_src, result_src,
  //        alu_src_a, alu_src_b, alu_op, retire, illegal}
  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [1:0]  imm;
    logic [15:0] cnt;
  } obs_t;

  stim_t       stim_q[$];
  obs_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_m  = 16'h0000;

  function automatic logic [15:0] exp_ctl(int st, logic mr, logic [6:0] op);
    logic pc = 0, br = 0, ir = 0, rw = 0, mw = 0, adr = 0, ret = 0, ill = 0;
    logic [1:0] rs = 0, a = 0, b = 0, ao = 0;
    case (st)
      0: begin pc = mr; ir = mr; b = 2'b10; rs = 2'b10; end
      1: begin
        a = 2'b01; b = 2'b01;
        ill = !(op == LW || op == SW || op == RT || op == IT || op == BEQ);
      end
      2: begin a = 2'b10; b = 2'b01; end
      3: adr = 1'b1;
      4: begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
      5: begin adr = 1'b1; mw = 1'b1; ret = mr; end
      6: begin a = 2'b10; ao = 2'b10; end
      7: begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      8: begin rw = 1'b1; ret = 1'b1; end
      9: begin a = 2'b10; ao = 2'b01; br = 1'b1; ret = 1'b1; end
      default: ;
    endcase
    return {pc, br, ir, rw, mw, adr, rs, a, b, ao, ret, ill};
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Queue one cycle: stimulus plus what the DUT must show during that cycle.
  task automatic push_cycle(int st, logic [6:0] op, logic mr, logic r);
    obs_t        e;
    logic [15:0] c;
    c     = exp_ctl(st, mr, op);
    e.st  = st[3:0];
    e.ctl = c;
    e.imm = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : 2'b00;
    e.cnt = cnt_m;
    exp_q.push_back(e);
    stim_q.push_back({r, op, mr});
    if (r) cnt_m = 16'h0000;
    else if (c[1]) cnt_m = cnt_m + 16'd1;
  endtask

  // Queue one whole instruction; op is garbage outside DECODE/MEMADR.
  task automatic plan_instr(logic [6:0] op, int fw, int mw);
    for (int i = 0; i < fw; i++) push_cycle(0, junk(), 1'b0, 1'b0);
    push_cycle(0, junk(), 1'b1, 1'b0);
    push_cycle(1, op, rbit(), 1'b0);
    case (op)
      LW: begin
        push_cycle(2, op, rbit(), 1'b0);
        for (int i = 0; i < mw; i++) push_cycle(3, junk(), 1'b0, 1'b0);
        push_cycle(3, junk(), 1'b1, 1'b0);
        push_cycle(4, junk(), rbit(), 1'b0);
      end
      SW: begin
        push_cycle(2, op, rbit(), 1'b0);
        for (int i = 0; i < mw; i++) push_cycle(5, junk(), 1'b0, 1'b0);
        push_cycle(5, junk(), 1'b1, 1'b0);
      end
      RT: begin push_cycle(6, junk(), rbit(), 1'b0); push_cycle(8, junk(), rbit(), 1'b0); end
      IT: begin push_cycle(7, junk(), rbit(), 1'b0); push_cycle(8, junk(), rbit(), 1'b0); end
      BEQ: push_cycle(9, junk(), rbit(), 1'b0);
      default: ;
    endcase
  endtask

  // Drive the next queued cycle and capture the DUT outputs mid-cycle.
  task automatic step(output obs_t e, output obs_t g);
    stim_t s;
    s = stim_q.pop_front();
    e = exp_q.pop_front();
    @(negedge clk);
    rst           = s.r;
    bus.op        = s.op;
    bus.mem_ready = s.mr;
    #1;
    g = {bus.state, bus.pc_update, bus.branch, bus.ir_write, bus.reg_write, bus.mem_write,
         bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.retire,
         bus.illegal, bus.imm_src, bus.retired_cnt};
  endtask

  task automatic test_reset();
    obs_t e, g;
    rst = 1'b1; bus.op = 7'h00; bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    cnt_m = 16'h0000;
    for (int i = 0; i < 3; i++) push_cycle(0, junk(), 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      step(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
    end
  endtask

  task automatic test_lw();
    obs_t e, g;
    plan_instr(LW, 0, 0);
    plan_instr(LW, 2, 1);
    while (exp_q.size() > 0) begin
      step(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL lw: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
    end
  endtask

  task automatic test_sw_wait();
    obs_t e, g;
    int   mw_cycles = 0;
    int   retires   = 0;
    plan_instr(SW, 0, 3);
    while (exp_q.size() > 0) begin
      step(e, g);
      mw_cycles += int'(g.ctl[11]);
      retires   += int'(g.ctl[1]);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sw: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
    end
    checks++;
    if (mw_cycles !== 4 || retires !== 1) begin
      errors++;
      $display("FAIL sw_pulses: got mem_write=%0d retire=%0d want 4 and 1", mw_cycles, retires);
    end
  endtask

  task automatic test_beq();
    obs_t e, g;
    int   seen = 0;
    push_cycle(0, BEQ, 1'b1, 1'b0);
    push_cycle(1, BEQ, 1'b1, 1'b0);
    push_cycle(9, BEQ, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      step(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL beq: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
      if (g.st == 4'd9 && g.ctl[14] && g.ctl[3:2] == 2'b01 && g.imm == 2'b10) seen++;
    end
    checks++;
    if (seen !== 1) begin
      errors++;
      $display("FAIL beq_state9: got %0d qualifying cycles want 1", seen);
    end
  endtask

  task automatic test_illegal();
    obs_t e, g;
    plan_instr(7'b1111111, 0, 0);
    plan_instr(7'b0000000, 1, 0);
    plan_instr(RT, 0, 0);
    while (exp_q.size() > 0) begin
      step(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL illegal: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    plan_instr(RT, 0, 0);
    plan_instr(IT, 1, 0);
    plan_instr(LW, 0, 2);
    plan_instr(SW, 2, 0);
    plan_instr(BEQ, 0, 0);
    plan_instr(IT, 0, 0);
    while (exp_q.size() > 0) begin
      step(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_memread();
    obs_t e, g;
    push_cycle(0, junk(), 1'b1, 1'b0);
    push_cycle(1, LW, 1'b1, 1'b0);
    push_cycle(2, LW, 1'b1, 1'b0);
    push_cycle(3, junk(), 1'b0, 1'b0);
    push_cycle(3, junk(), 1'b0, 1'b1);
    push_cycle(0, junk(), 1'b0, 1'b0);
    push_cycle(0, junk(), 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      step(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rst_memread: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
    end
  endtask

  // Preload the counter near its top instead of retiring 65535 instructions.
  task automatic test_wrap();
    obs_t e, g;
    @(negedge clk);
    force dut.retired_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.retired_cnt_q;
    cnt_m = 16'hFFFE;
    plan_instr(RT, 0, 0);
    plan_instr(BEQ, 0, 0);
    plan_instr(RT, 0, 0);
    push_cycle(0, junk(), 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      step(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL wrap: got st=%0d ctl=%h imm=%b cnt=%h want st=%0d ctl=%h imm=%b cnt=%h",
                 g.st, g.ctl, g.imm, g.cnt, e.st, e.ctl, e.imm, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid_memread();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
